// File: rtl/motor_pwm_decode.sv
// motor_pwm_decode: recovers a signed speed command from one motor
// channel's fwd/rev PWM pins by measuring high-time over a W-cycle window.
module motor_pwm_decode #(
  parameter int PERIOD_BITS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fwd,
  input  logic                 rev,
  output logic [PERIOD_BITS:0] cmd,
  output logic                 cmd_vld,
  output logic                 brake,
  output logic                 err
);

  localparam int CW = PERIOD_BITS + 1;

  // W itself, and the largest magnitude the command may carry (W-1)
  localparam logic [CW-1:0] W_FULL = {1'b1, {PERIOD_BITS{1'b0}}};
  localparam logic [CW-1:0] W_MAX  = {1'b0, {PERIOD_BITS{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    REPORT
  } state_t;

  state_t state;

  logic [PERIOD_BITS-1:0] wc;
  logic [CW-1:0] f_acc;
  logic [CW-1:0] r_acc;
  logic [CW-1:0] b_acc;

  logic [CW-1:0] f_nxt;
  logic [CW-1:0] r_nxt;
  logic [CW-1:0] b_nxt;
  logic [CW-1:0] f_sat;
  logic [CW-1:0] r_sat;
  logic          sampling;
  logic          close;

  logic          b_full;
  logic          b_part;
  logic          flip;
  logic          fwd_only;
  logic          rev_only;

  logic [CW-1:0] cls_cmd;
  logic          cls_brk;
  logic          cls_err;

  // Counts including this cycle's sample; close-out classifies on these
  always_comb begin
    f_nxt    = f_acc + CW'(fwd);
    r_nxt    = r_acc + CW'(rev);
    b_nxt    = b_acc + CW'(fwd & rev);
    sampling = (state != IDLE);
    close    = sampling && (wc == '1);
  end

  // Clamp a full-window count of W down to W-1
  always_comb begin
    f_sat = f_nxt[PERIOD_BITS] ? W_MAX : f_nxt;
    r_sat = r_nxt[PERIOD_BITS] ? W_MAX : r_nxt;
  end

  // Mutually exclusive window classes
  always_comb begin
    b_full   = (b_nxt == W_FULL);
    b_part   = (b_nxt != '0) && !b_full;
    flip     = (b_nxt == '0) && (f_nxt != '0)
             && (r_nxt != '0);
    fwd_only = (b_nxt == '0) && (r_nxt == '0);
    rev_only = (b_nxt == '0) && (f_nxt == '0)
             && (r_nxt != '0);
  end

  // Map the window class onto the reported command and flags
  always_comb begin
    cls_cmd = '0;
    cls_brk = 1'b0;
    cls_err = 1'b0;
    unique case (1'b1)
      b_full:   cls_brk = 1'b1;
      b_part:   cls_err = 1'b1;
      flip:     cls_err = 1'b1;
      fwd_only: cls_cmd = f_sat;
      rev_only: cls_cmd = -r_sat;
      default: begin
        cls_cmd = '0;
        cls_brk = 1'b0;
        cls_err = 1'b0;
      end
    endcase
  end

  // Window counter and accumulators; restart from zero at close-out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wc    <= '0;
      f_acc <= '0;
      r_acc <= '0;
      b_acc <= '0;
    end else if (sampling) begin
      wc <= wc + 1'b1;
      if (close) begin
        f_acc <= '0;
        r_acc <= '0;
        b_acc <= '0;
      end else begin
        f_acc <= f_nxt;
        r_acc <= r_nxt;
        b_acc <= b_nxt;
      end
    end
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd     <= '0;
      cmd_vld <= 1'b0;
      brake   <= 1'b0;
      err     <= 1'b0;
    end else begin
      cmd_vld <= 1'b0;
      unique case (state)
        IDLE: state <= MEAS;
        MEAS: begin
          if (close) begin
            state   <= REPORT;
            cmd_vld <= 1'b1;
            cmd     <= cls_cmd;
            brake   <= cls_brk;
            err     <= cls_err;
          end
        end
        REPORT: state <= MEAS;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_motor_pwm_decode.sv
// tb_motor_pwm_decode: directed windows with hand-computed results,
// checked by a scoreboard monitor on every cmd_vld pulse.
module tb_motor_pwm_decode;

  localparam int PB = 10;
  localparam int W  = 1 << PB;

  logic          clk;
  logic          rst_n;
  logic          fwd;
  logic          rev;
  logic [PB:0]   cmd;
  logic          cmd_vld;
  logic          brake;
  logic          err;

  typedef struct packed {
    logic [PB:0] cmd;
    logic        brk;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  motor_pwm_decode #(.PERIOD_BITS(PB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .fwd     (fwd),
    .rev     (rev),
    .cmd     (cmd),
    .cmd_vld (cmd_vld),
    .brake   (brake),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h",
               name, act, req);
    end
  endtask

  function automatic logic in_rng(input int i,
                                  input int st,
                                  input int len);
    return ((i - st + W) % W) < len;
  endfunction

  // One full window; expectation is queued before the last sample
  task automatic run_window(input int f_st, input int f_len,
                            input int r_st, input int r_len,
                            input logic [PB:0] ecmd,
                            input logic ebrk,
                            input logic eerr);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      fwd = in_rng(i, f_st, f_len);
      rev = in_rng(i, r_st, r_len);
      if (i == W - 1) begin
        e.cmd = ecmd;
        e.brk = ebrk;
        e.err = eerr;
        exp_q.push_back(e);
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cmd"}, 32'(cmd), 32'h0);
    chk({tag, "_vld"}, 32'(cmd_vld), 32'h0);
    chk({tag, "_brake"}, 32'(brake), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && cmd_vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_vld", 32'(cmd_vld), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cmd", 32'(cmd), 32'(e.cmd));
        chk("brake", 32'(brake), 32'(e.brk));
        chk("err", 32'(err), 32'(e.err));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    fwd   = 1'b0;
    rev   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst0");
    rst_n = 1'b1;
    @(negedge clk);

    // fwd duty 300 at two phases
    run_window(900, 300, 0, 0, 11'h12C, 1'b0, 1'b0);
    run_window(17, 300, 0, 0, 11'h12C, 1'b0, 1'b0);
    // rev duty 1023, then held high (saturates)
    run_window(0, 0, 5, 1023, 11'h401, 1'b0, 1'b0);
    run_window(0, 0, 0, W, 11'h401, 1'b0, 1'b0);
    run_window(0, 0, 0, W, 11'h401, 1'b0, 1'b0);
    // full brake then coast
    run_window(0, W, 0, W, 11'h000, 1'b1, 1'b0);
    run_window(0, 0, 0, 0, 11'h000, 1'b0, 1'b0);
    // fwd held high saturates to +1023
    run_window(0, W, 0, 0, 11'h3FF, 1'b0, 1'b0);
    // single rev cycle gives -1
    run_window(0, 0, 700, 1, 11'h7FF, 1'b0, 1'b0);
    // shoot-through overlap of 3 cycles
    run_window(0, 500, 497, 3, 11'h000, 1'b0, 1'b1);
    // direction flip inside window, then steady rev 200
    run_window(100, 200, 600, 200, 11'h000, 1'b0, 1'b1);
    run_window(0, 0, 600, 200, 11'h738, 1'b0, 1'b0);

    // reset at wc=600 with a heavy fwd duty in progress
    for (int i = 0; i < 600; i++) begin
      fwd = in_rng(i, 0, 700);
      rev = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_reset_outs("rst_mid");
    fwd = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_outs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run_window(300, 100, 0, 0, 11'h064, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("pending", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
